// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and flush controller for an in-order N-stage MIPS pipeline.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES       = 5,
  parameter int REG_ADDR_W       = 5,
  parameter int REDIRECT_STAGE   = 3,
  parameter int LOAD_READY_STAGE = 3,
  localparam int SEL_W           = $clog2(NUM_STAGES)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  IdValid,
  input  logic [REG_ADDR_W-1:0] IdRs,
  input  logic [REG_ADDR_W-1:0] IdRt,
  input  logic                  IdUsesRs,
  input  logic                  IdUsesRt,
  input  logic [REG_ADDR_W-1:0] IdDest,
  input  logic                  IdRegWrite,
  input  logic                  IdIsLoad,
  input  logic                  IdJump,
  input  logic                  BranchTaken,
  output logic                  Stall,
  output logic                  JumpFire,
  output logic [NUM_STAGES-2:0] FlushVec,
  output logic [SEL_W-1:0]      FwdSelRs,
  output logic [SEL_W-1:0]      FwdSelRt,
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regWrite;
    logic                  isLoad;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  usesRs;
    logic                  usesRt;
  } recT;

  recT  rec [2:NUM_STAGES-1];
  logic loadHit;
  logic anyValid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int s = 2; s < NUM_STAGES; s++) rec[s] <= '0;
    end else begin
      // Wrong-path records younger than the resolving branch become bubbles.
      for (int s = NUM_STAGES-1; s >= 3; s--) begin
        rec[s] <= rec[s-1];
        if (BranchTaken && s <= REDIRECT_STAGE) rec[s].valid <= 1'b0;
      end
      rec[2] <= '{valid: IdValid & ~Stall & ~BranchTaken, dest: IdDest,
                  regWrite: IdRegWrite, isLoad: IdIsLoad, rs: IdRs, rt: IdRt,
                  usesRs: IdUsesRs, usesRt: IdUsesRt};
    end
  end

  always_comb begin
    loadHit  = 1'b0;
    anyValid = 1'b0;
    for (int s = 2; s < NUM_STAGES; s++) anyValid = anyValid | rec[s].valid;
    for (int s = 2; s < LOAD_READY_STAGE; s++) begin
      if (rec[s].valid && rec[s].isLoad && rec[s].regWrite && rec[s].dest != '0 &&
          ((rec[s].dest == IdRs && IdUsesRs) || (rec[s].dest == IdRt && IdUsesRt)))
        loadHit = 1'b1;
    end
  end

  assign Stall    = ~Reset & IdValid & ~BranchTaken & loadHit;
  assign JumpFire = ~Reset & anyValid & IdJump & IdValid & ~Stall & ~BranchTaken;

  always_comb begin
    FlushVec = '0;
    if (!Reset && anyValid) begin
      if (BranchTaken) begin
        for (int k = 0; k < REDIRECT_STAGE-1; k++) FlushVec[k] = 1'b1;
      end else if (JumpFire) begin
        FlushVec[0] = 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the youngest eligible producer overwrites last.
  always_comb begin
    FwdSelRs = '0;
    FwdSelRt = '0;
    if (rec[2].valid) begin
      for (int s = NUM_STAGES-1; s >= 3; s--) begin
        if (rec[s].valid && rec[s].regWrite && rec[s].dest != '0 &&
            (!rec[s].isLoad || s > LOAD_READY_STAGE)) begin
          if (rec[2].usesRs && rec[s].dest == rec[2].rs) FwdSelRs = SEL_W'(s);
          if (rec[2].usesRt && rec[s].dest == rec[2].rt) FwdSelRt = SEL_W'(s);
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (Stall && stallCnt != 32'hFFFF_FFFF) stallCnt <= stallCnt + 32'd1;
      if ((BranchTaken || JumpFire) && flushCnt != 32'hFFFF_FFFF) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign StallCount = stallCnt;
  assign FlushCount = flushCnt;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule
